dataram_lsu: RTL and testbench

//  Parametrised data memory with a built-in load/store unit for the RISC-V core's MEM stage.

---
 rtl/dataram_lsu.sv | 147 ++++++++++++++
 tb/tb_dataram_lsu.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dataram_lsu.sv
// Data memory with an integrated load/store unit for the MEM stage.
// Stores write byte lanes at the accepting edge. Loads return one cycle
// later through a single response slot that supports backpressure.
// Misaligned and out-of-range accesses raise flags and never write memory.
module dataram_lsu #(
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        misalign_err,
  output logic        oob_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] mem [DEPTH_WORDS];

  logic            accept;
  logic            misalign;
  logic            oob_any;
  logic            oob_only;
  logic            req_ok;
  logic            wr_en;
  logic            rd_en;
  logic [AW-1:0]   idx;
  logic [3:0]      byte_en;
  logic [3:0][7:0] lane_wdata;

  logic            rsp_valid_reg;
  logic            misalign_reg;
  logic            oob_reg;
  logic            zero_reg;
  logic [1:0]      size_reg;
  logic [1:0]      lane_reg;
  logic            unsigned_reg;
  logic [31:0]     raw_word_reg;

  // One response slot: a new request may enter only if the slot is free or
  // being drained this cycle.
  assign req_ready = !rst && !(rsp_valid_reg && !rsp_ready);
  assign accept    = req_valid && req_ready;

  assign misalign = (req_size == 2'b11) ||
                    ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  // Upper address bits only take part in this range test.
  assign oob_any  = ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign oob_only = oob_any && !misalign;
  assign req_ok   = !misalign && !oob_any;

  assign idx   = req_addr[AW+1:2];
  assign wr_en = accept && req_we && req_ok && !rst;
  assign rd_en = accept && !req_we && req_ok;

  // Per-lane enable and data steering; stores arrive right-aligned.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_en[gi] = (req_size == 2'b10) ||
                           ((req_size == 2'b01) && (req_addr[1] == 1'(gi / 2))) ||
                           ((req_size == 2'b00) && (req_addr[1:0] == 2'(gi)));
      assign lane_wdata[gi] = (req_size == 2'b10) ? req_wdata[gi*8 +: 8] :
                              (req_size == 2'b01) ? req_wdata[(gi % 2)*8 +: 8] :
                                                    req_wdata[7:0];
    end
  endgenerate

  // Byte-enabled write port of the memory array.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[idx][b*8 +: 8] <= lane_wdata[b];
        end
      end
    end
  end

  // Registered read port; the word is held until the next accepted load.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      raw_word_reg <= mem[idx];
    end
  end

  // Response slot and error flags: loads fill the slot, stores only pulse
  // the flags, and a stalled response keeps everything frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_reg <= 1'b0;
      misalign_reg  <= 1'b0;
      oob_reg       <= 1'b0;
      zero_reg      <= 1'b1;
      size_reg      <= 2'b00;
      lane_reg      <= 2'b00;
      unsigned_reg  <= 1'b0;
    end else if (accept) begin
      misalign_reg <= misalign;
      oob_reg      <= oob_only;
      if (req_we) begin
        rsp_valid_reg <= 1'b0;
      end else begin
        rsp_valid_reg <= 1'b1;
        zero_reg      <= !req_ok;
        size_reg      <= req_size;
        lane_reg      <= req_addr[1:0];
        unsigned_reg  <= req_unsigned;
      end
    end else if (!(rsp_valid_reg && !rsp_ready)) begin
      rsp_valid_reg <= 1'b0;
      misalign_reg  <= 1'b0;
      oob_reg       <= 1'b0;
    end
  end

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Lane selection and sign/zero extension of the stored word.
  always_comb begin
    lane_byte = raw_word_reg[lane_reg*8 +: 8];
    lane_half = lane_reg[1] ? raw_word_reg[31:16] : raw_word_reg[15:0];
    rsp_rdata = 32'h0;
    if (!zero_reg) begin
      case (size_reg)
        2'b00:   rsp_rdata = {{24{!unsigned_reg && lane_byte[7]}}, lane_byte};
        2'b01:   rsp_rdata = {{16{!unsigned_reg && lane_half[15]}}, lane_half};
        default: rsp_rdata = raw_word_reg;
      endcase
    end
  end

  assign rsp_valid    = rsp_valid_reg;
  assign misalign_err = misalign_reg;
  assign oob_err      = oob_reg;

endmodule

// File: tb/tb_dataram_lsu.sv
// Directed and randomized checks of dataram_lsu against a word-array model.
module tb_dataram_lsu;

  localparam int DEPTH = 64;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        misalign_err;
  logic        oob_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] model_mem [DEPTH];

  dataram_lsu #(.DEPTH_WORDS(DEPTH), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .misalign_err(misalign_err), .oob_err(oob_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic bit m_mis(input logic [31:0] a, input logic [1:0] s);
    return (s == 3) || (s == 1 && (a % 2) != 0) || (s == 2 && (a % 4) != 0);
  endfunction

  function automatic bit m_oob(input logic [31:0] a, input logic [1:0] s);
    return !m_mis(a, s) && ((a / 4) >= DEPTH);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] s, input logic u);
    logic [31:0] w, v;
    int sh;
    if (m_mis(a, s) || (a / 4) >= DEPTH) return 32'h0;
    w  = model_mem[a / 4];
    sh = 8 * int'(a % 4);
    if (s == 0) begin
      v = (w >> sh) & 32'hFF;
      if (!u && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (s == 1) begin
      v = (w >> sh) & 32'hFFFF;
      if (!u && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic void m_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    logic [31:0] mask;
    int sh;
    if (m_mis(a, s) || (a / 4) >= DEPTH) return;
    sh = 8 * int'(a % 4);
    if (s == 2) begin
      model_mem[a / 4] = d;
    end else begin
      mask = (s == 0) ? 32'hFF : 32'hFFFF;
      model_mem[a / 4] = (model_mem[a / 4] & ~(mask << sh)) | ((d & mask) << sh);
    end
  endfunction

  task automatic drive(input logic we, input logic [31:0] a, input logic [1:0] s,
                       input logic u, input logic [31:0] d);
    req_valid = 1'b1; req_we = we; req_addr = a; req_size = s;
    req_unsigned = u; req_wdata = d;
  endtask

  // One accepted request followed by an idle cycle that checks the flags fell.
  task automatic access(input logic we, input logic [31:0] a, input logic [1:0] s,
                        input logic u, input logic [31:0] d);
    logic [31:0] exp_data;
    drive(we, a, s, u, d);
    #1 check("req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    exp_data = m_load(a, s, u);
    if (we) m_store(a, s, d);
    @(negedge clk);
    check("rsp_valid", 32'(rsp_valid), 32'(!we));
    check("misalign_err", 32'(misalign_err), 32'(m_mis(a, s)));
    check("oob_err", 32'(oob_err), 32'(m_oob(a, s)));
    if (!we) check("rsp_rdata", rsp_rdata, exp_data);
    $display("txn we=%0d addr=%h size=%0d uns=%0d wdata=%h rdata=%h mis=%0d oob=%0d",
             we, a, s, u, d, rsp_rdata, misalign_err, oob_err);
    @(negedge clk);
    check("idle_valid", 32'(rsp_valid), 32'd0);
    check("idle_flags", {30'd0, misalign_err, oob_err}, 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    rst = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_flags", {30'd0, misalign_err, oob_err}, 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1 check("ready_after_rst", 32'(req_ready), 32'd1);

    // Give every word a known value
    for (int i = 0; i < DEPTH; i++) access(1'b1, 32'(i * 4), 2'd2, 1'b0, $urandom);

    // Word store / load
    access(1'b1, 32'h4, 2'd2, 1'b0, 32'h8000_00F1);
    access(1'b0, 32'h4, 2'd2, 1'b0, 32'h0);

    // Byte lanes and extension
    access(1'b1, 32'h8, 2'd2, 1'b0, 32'h0);
    access(1'b1, 32'hA, 2'd0, 1'b0, 32'h85);
    access(1'b0, 32'h8, 2'd2, 1'b0, 32'h0);
    access(1'b0, 32'hA, 2'd0, 1'b0, 32'h0);
    access(1'b0, 32'hA, 2'd0, 1'b1, 32'h0);

    // Halves: aligned store, misaligned store, misaligned load, illegal size
    access(1'b1, 32'h6, 2'd1, 1'b0, 32'h0000_9234);
    access(1'b0, 32'h6, 2'd1, 1'b0, 32'h0);
    access(1'b0, 32'h6, 2'd1, 1'b1, 32'h0);
    access(1'b1, 32'h5, 2'd1, 1'b0, 32'h0000_1234);
    access(1'b0, 32'h4, 2'd2, 1'b0, 32'h0);
    access(1'b0, 32'h1, 2'd1, 1'b0, 32'h0);
    access(1'b0, 32'h8, 2'd3, 1'b0, 32'h0);

    // Out of range, and misalign priority over oob
    access(1'b0, 32'(4 * DEPTH), 2'd2, 1'b0, 32'h0);
    access(1'b1, 32'(4 * DEPTH), 2'd2, 1'b0, 32'hDEAD_BEEF);
    access(1'b0, 32'h0, 2'd2, 1'b0, 32'h0);
    access(1'b0, 32'(4 * DEPTH + 1), 2'd1, 1'b0, 32'h0);
    access(1'b0, 32'hFFFF_FFFC, 2'd2, 1'b0, 32'h0);

    // Backpressure holds the response and blocks new requests
    rsp_ready = 1'b0;
    drive(1'b0, 32'h4, 2'd2, 1'b0, 32'h0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    held = m_load(32'h4, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata", rsp_rdata, held);
      check("bp_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1 check("bp_release_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("bp_drained", 32'(rsp_valid), 32'd0);

    // Store then load on consecutive accepts, then back-to-back loads
    drive(1'b1, 32'h10, 2'd2, 1'b0, 32'hCAFE_1234);
    @(posedge clk);
    m_store(32'h10, 2'd2, 32'hCAFE_1234);
    #1 drive(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    @(posedge clk);
    #1 drive(1'b0, 32'h12, 2'd0, 1'b0, 32'h0);
    check("b2b_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("raw_rdata", rsp_rdata, m_load(32'h10, 2'd2, 1'b0));
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("b2b_valid", 32'(rsp_valid), 32'd1);
    check("b2b_rdata", rsp_rdata, m_load(32'h12, 2'd0, 1'b0));
    @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      access(1'($urandom_range(0, 1)), 32'($urandom_range(0, 4 * DEPTH + 7)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
    end

    // Reset during a pending response, and a store presented during reset
    rsp_ready = 1'b0;
    drive(1'b0, 32'h4, 2'd2, 1'b0, 32'h0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid_rdata", rsp_rdata, 32'd0);
    drive(1'b1, 32'h0, 2'd2, 1'b0, 32'h1357_9BDF);
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    access(1'b0, 32'h0, 2'd2, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
